// File: rtl/result_buffer_pkg.sv
// Shared types and constants for the accelerator result buffer.
package result_buffer_pkg;

   localparam int RESULT_DATA_W    = 21;
   localparam int RESULT_BUF_DEPTH = 8;

   // One result word: 2-bit integer part above the shifted fraction.
   typedef logic [RESULT_DATA_W-1:0] result_word_t;

endpackage

// File: rtl/result_buf_mem.sv
// Register-array storage for the result buffer: synchronous write port,
// combinational read port, contents are not reset.
module result_buf_mem #(
   parameter int DATA_W = 21,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Store the incoming word at the write address.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/result_buffer.sv
// Result buffer: captures every accelerator write beat into a FIFO that a
// consumer drains with a first-word-fall-through pop handshake.
// The write side cannot be stalled; a beat that cannot be stored sets the
// sticky overflow flag.
// Optional build macro RESULT_BUFFER_DROP_OLDEST_EN: a write into a full
// buffer without a pop overwrites the oldest entry instead of being dropped.
//
// Handshake: rd_valid is high whenever the buffer holds a word and rd_data
// shows that head word; a pop happens on a rising edge where rd_req and
// rd_valid are both high. rd_req while empty is ignored. wr_req has no ready:
// a beat is offered on every high cycle and is either stored or counted as
// an overflow.
module result_buffer
   import result_buffer_pkg::*;
#(
   parameter int DATA_W = RESULT_DATA_W,
   parameter int DEPTH  = RESULT_BUF_DEPTH,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   input  logic              clr_ovf
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [DATA_W-1:0] mem_rdata;
   logic              pop;
   logic              push;
   logic              blocked;
   logic              mem_we;
   logic              rd_adv;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign rd_valid = !empty;
   // Memory is not reset, so hide whatever it holds while nothing is queued.
   assign rd_data  = empty ? '0 : mem_rdata;

   // Decode this cycle's push, pop and blocked-write conditions.
   always_comb begin
      pop     = rd_req && !empty;
      push    = wr_req && (!full || pop);
      blocked = wr_req && full && !pop;
`ifdef RESULT_BUFFER_DROP_OLDEST_EN
      // A blocked write replaces the oldest word: both pointers advance.
      mem_we  = push || blocked;
      rd_adv  = pop || blocked;
`else
      mem_we  = push;
      rd_adv  = pop;
`endif
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (mem_we) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_adv) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Sticky overflow; a new overflow wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (blocked) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   result_buf_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk    (clk),
      .we     (mem_we && !rst),
      .waddr  (wr_ptr),
      .wdata  (wr_data),
      .raddr  (rd_ptr),
      .rdata  (mem_rdata)
   );

endmodule

// File: tb/tb_result_buffer.sv
// Directed bench for result_buffer. Expected read words are queued when
// written; a monitor compares each popped word against the queue head.
module tb_result_buffer;

   localparam int DATA_W = 21;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              rst;
   logic              wr_req;
   logic [DATA_W-1:0] wr_data;
   logic              rd_req;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              clr_ovf;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_q[$];

   result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_req   (wr_req),
      .wr_data  (wr_data),
      .rd_req   (rd_req),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: a pop is committed on the coming edge, so compare
   // the presented head word at the falling edge before it.
   always @(negedge clk) begin
      if (!rst && rd_req && rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_data: got %h, expected queue empty", rd_data);
         end else begin
            if (rd_data !== exp_q[0]) begin
               errors++;
               $display("FAIL pop_data: got %h, expected %h", rd_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Driver tasks
   task automatic do_write(input logic [DATA_W-1:0] d);
      wr_req  = 1'b1;
      wr_data = d;
      tick();
      wr_req  = 1'b0;
   endtask

   task automatic do_pops(input int n);
      rd_req = 1'b1;
      for (int i = 0; i < n; i++) tick();
      rd_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      rst     = 1'b1;
      wr_req  = 1'b0;
      wr_data = '0;
      rd_req  = 1'b0;
      clr_ovf = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_valid", 32'(rd_valid), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_data", 32'(rd_data), 0);

      // Three writes, then drain in order
      exp_q.push_back(21'h00100); do_write(21'h00100);
      check("t1_fwft_data", 32'(rd_data), 32'h00100);
      exp_q.push_back(21'h10000); do_write(21'h10000);
      exp_q.push_back(21'h1FFFF); do_write(21'h1FFFF);
      check("t1_count", 32'(count), 3);
      check("t1_head", 32'(rd_data), 32'h00100);
      do_pops(3);
      check("t1_empty", 32'(empty), 1);
      check("t1_q_drained", 32'(exp_q.size()), 0);

      // Nine writes into eight entries
      for (int i = 1; i <= 9; i++) begin
`ifdef RESULT_BUFFER_DROP_OLDEST_EN
         if (i == 9) void'(exp_q.pop_front());
         exp_q.push_back(DATA_W'(i));
`else
         if (i <= 8) exp_q.push_back(DATA_W'(i));
`endif
         do_write(DATA_W'(i));
         if (i == 8) begin
            check("t2_full8", 32'(full), 1);
            check("t2_ovf8", 32'(overflow), 0);
         end
      end
      check("t2_ovf9", 32'(overflow), 1);
      check("t2_count9", 32'(count), 8);
      check("t2_full9", 32'(full), 1);
      do_pops(8);
      check("t2_empty", 32'(empty), 1);
      check("t2_ovf_sticky", 32'(overflow), 1);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("t2_ovf_clr", 32'(overflow), 0);

      // Full with simultaneous write and pop
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(21'h00100 + DATA_W'(i));
         do_write(21'h00100 + DATA_W'(i));
      end
      check("t3_full", 32'(full), 1);
      exp_q.push_back(21'hAAAAA);
      rd_req = 1'b1;
      do_write(21'hAAAAA);
      rd_req = 1'b0;
      check("t3_count", 32'(count), 8);
      check("t3_ovf", 32'(overflow), 0);
      do_pops(8);
      check("t3_empty", 32'(empty), 1);
      check("t3_q_drained", 32'(exp_q.size()), 0);

      // Empty with simultaneous write and pop request
      rd_req = 1'b1;
      do_write(21'h12345);
      rd_req = 1'b0;
      check("t4_count", 32'(count), 1);
      check("t4_valid", 32'(rd_valid), 1);
      check("t4_data", 32'(rd_data), 32'h12345);
      exp_q.push_back(21'h12345);
      do_pops(1);
      check("t4_empty", 32'(empty), 1);

      // Pointer wrap: 20 write/pop pairs
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back(21'h15000 + DATA_W'(i * 'h111));
         do_write(21'h15000 + DATA_W'(i * 'h111));
         check("t5_count_one", 32'(count), 1);
         do_pops(1);
         check("t5_count_zero", 32'(count), 0);
      end
      check("t5_q_drained", 32'(exp_q.size()), 0);

      // Overflow set wins over clear, then reset mid-stream
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(21'h0C000 + DATA_W'(i));
         do_write(21'h0C000 + DATA_W'(i));
      end
`ifdef RESULT_BUFFER_DROP_OLDEST_EN
      void'(exp_q.pop_front());
      exp_q.push_back(21'h0DEAD);
`endif
      do_write(21'h0DEAD);
      check("t6_ovf_set", 32'(overflow), 1);
`ifdef RESULT_BUFFER_DROP_OLDEST_EN
      void'(exp_q.pop_front());
      exp_q.push_back(21'h0BEEF);
`endif
      clr_ovf = 1'b1;
      do_write(21'h0BEEF);
      clr_ovf = 1'b0;
      check("t6_ovf_set_wins", 32'(overflow), 1);
      check("t6_count_full", 32'(count), 8);
      do_pops(3);
      check("t6_count5", 32'(count), 5);
      wr_req  = 1'b1;
      wr_data = 21'h1ABCD;
      do_reset();
      wr_req  = 1'b0;
      check("t6_rst_count", 32'(count), 0);
      check("t6_rst_empty", 32'(empty), 1);
      check("t6_rst_ovf", 32'(overflow), 0);
      check("t6_rst_data", 32'(rd_data), 0);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
